// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data access, one transaction in flight.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to force-complete transactions after TIMEOUT_CYCLES.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    input  logic                    i_if_kill,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    output logic                    o_if_rvalid,
    input  logic                    i_dm_req,
    input  logic                    i_dm_we,
    input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_dm_be,
    output logic [DATA_WIDTH-1:0]   o_dm_rdata,
    output logic                    o_dm_rvalid,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_stall_f,
    output logic                    o_stall_m,
    output logic                    o_timeout
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_owner_q, last_owner_d;
    logic                  killed_q, killed_d;
    logic                  timeout_q, timeout_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;

    logic if_cand;
    logic grant_if;
    logic grant_dm;
    logic mem_done;
    logic force_done;
    logic complete;
    logic cnt_hit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter starts at zero in the first ISSUE cycle, so it fires in busy cycle TIMEOUT_CYCLES.
    assign cnt_hit = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (grant_if || grant_dm) begin
            cnt_d = '0;
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No watchdog in this build; the comparison is constant false and keeps TIMEOUT_CYCLES referenced.
    assign cnt_hit = (TIMEOUT_CYCLES < 0);
`endif

    assign if_cand  = i_if_req & ~i_if_kill;
    assign grant_if = (state_q == ST_IDLE) & if_cand & (~i_dm_req | (last_owner_q == OWN_DM));
    assign grant_dm = (state_q == ST_IDLE) & i_dm_req & (~if_cand | (last_owner_q == OWN_IF));

    assign mem_done   = ((state_q == ST_ISSUE) & i_mem_gnt & i_mem_rvalid)
                      | ((state_q == ST_WAIT) & i_mem_rvalid);
    assign force_done = cnt_hit & ~mem_done;
    assign complete   = mem_done | force_done;

    // A fetch killed in its completion cycle is suppressed too, matching o_stall_f.
    assign o_if_rvalid = complete & (owner_q == OWN_IF) & ~killed_q & ~i_if_kill;
    assign o_dm_rvalid = complete & (owner_q == OWN_DM);
    assign o_if_rdata  = force_done ? '0 : i_mem_rdata;
    assign o_dm_rdata  = force_done ? '0 : i_mem_rdata;

    assign o_mem_req   = (state_q == ST_ISSUE);
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;
    assign o_timeout   = timeout_q;

    assign o_stall_f = i_if_req & ~o_if_rvalid & ~i_if_kill;
    assign o_stall_m = i_dm_req & ~o_dm_rvalid;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        killed_d     = killed_q;
        timeout_d    = timeout_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_if) begin
                    state_d      = ST_ISSUE;
                    owner_d      = OWN_IF;
                    last_owner_d = OWN_IF;
                    killed_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_if_addr;
                    mem_wdata_d  = '0;
                    mem_be_d     = '1;
                end else if (grant_dm) begin
                    state_d      = ST_ISSUE;
                    owner_d      = OWN_DM;
                    last_owner_d = OWN_DM;
                    killed_d     = 1'b0;
                    mem_we_d     = i_dm_we;
                    mem_addr_d   = i_dm_addr;
                    mem_wdata_d  = i_dm_wdata;
                    mem_be_d     = i_dm_be;
                end
            end
            ST_ISSUE: begin
                if (i_mem_gnt) begin
                    state_d = i_mem_rvalid ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && (owner_q == OWN_IF) && i_if_kill) begin
            killed_d = 1'b1;
        end
        if (complete) begin
            state_d  = ST_IDLE;
            killed_d = 1'b0;
        end
        if (force_done) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_DM;
            killed_q     <= 1'b0;
            timeout_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            killed_q     <= killed_d;
            timeout_q    <= timeout_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction table plus hand sequences, checked by a scoreboard.
module tb_mem_port_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_if_kill;
    logic [31:0] o_if_rdata;
    logic        o_if_rvalid;
    logic        i_dm_req;
    logic        i_dm_we;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic [3:0]  i_dm_be;
    logic [31:0] o_dm_rdata;
    logic        o_dm_rvalid;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_stall_f;
    logic        o_stall_m;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          chk_wdata;
    } iss_t;

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        bit          is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gdly;
        int          rdly;
        logic [31:0] rdata;
        logic        exp_we;
        logic [3:0]  exp_be;
    } vec_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];

    mem_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .i_if_kill    (i_if_kill),
        .o_if_rdata   (o_if_rdata),
        .o_if_rvalid  (o_if_rvalid),
        .i_dm_req     (i_dm_req),
        .i_dm_we      (i_dm_we),
        .i_dm_addr    (i_dm_addr),
        .i_dm_wdata   (i_dm_wdata),
        .i_dm_be      (i_dm_be),
        .o_dm_rdata   (o_dm_rdata),
        .o_dm_rvalid  (o_dm_rvalid),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_be     (o_mem_be),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_stall_f    (o_stall_f),
        .o_stall_m    (o_stall_m),
        .o_timeout    (o_timeout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_stall(input bit is_dm, input logic exp);
        if (is_dm) chk("stall_m", {31'b0, o_stall_m}, {31'b0, exp});
        else       chk("stall_f", {31'b0, o_stall_f}, {31'b0, exp});
    endtask

    // Drive point: 2 time units after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    // Acts as the memory: waits for o_mem_req, grants after gdly cycles, responds rdly cycles after grant.
    task automatic serve(input bit is_dm, input bit pulse, input int gdly, input int rdly,
                         input logic [31:0] rdata, output int waited);
        waited = 0;
        while (o_mem_req !== 1'b1 && waited < 40) begin
            #1 chk_stall(is_dm, 1'b1);
            tick();
            waited++;
        end
        if (o_mem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL serve_no_req: o_mem_req=%b required 1 within 40 cycles", o_mem_req);
            return;
        end
        for (int i = 0; i < gdly; i++) begin
            #1 chk_stall(is_dm, 1'b1);
            tick();
        end
        i_mem_gnt = 1'b1;
        if (rdly > 0) begin
            #1 chk_stall(is_dm, 1'b1);
            tick();
            i_mem_gnt = 1'b0;
            for (int i = 1; i < rdly; i++) begin
                #1 chk_stall(is_dm, 1'b1);
                tick();
            end
        end
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rdata;
        if (pulse) rsp_q.push_back('{is_dm, rdata});
        #1;
        if (pulse) chk_stall(is_dm, 1'b0);
        tick();
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
    endtask

    // Scoreboard monitor: compares issued requests and completions against the expectation queues.
    initial begin : monitor
        logic prev_req;
        iss_t cur;
        rsp_t r;
        prev_req = 1'b0;
        cur = '{default: '0};
        forever begin
            @(negedge i_clk);
            if (o_mem_req === 1'b1 && !prev_req) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: addr 0x%08h issued with no request pending", o_mem_addr);
                end else begin
                    cur = iss_q.pop_front();
                    chk("issue_addr", o_mem_addr, cur.addr);
                    chk("issue_we", {31'b0, o_mem_we}, {31'b0, cur.we});
                    chk("issue_be", {28'b0, o_mem_be}, {28'b0, cur.be});
                    if (cur.chk_wdata) chk("issue_wdata", o_mem_wdata, cur.wdata);
                end
            end else if (o_mem_req === 1'b1) begin
                chk("hold_addr", o_mem_addr, cur.addr);
                chk("hold_fields", {27'b0, o_mem_we, o_mem_be}, {27'b0, cur.we, cur.be});
            end
            prev_req = (o_mem_req === 1'b1);

            if (o_if_rvalid === 1'b1 || o_dm_rvalid === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected: if_rvalid=%b dm_rvalid=%b with no completion pending",
                             o_if_rvalid, o_dm_rvalid);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rvalid_port", {30'b0, o_dm_rvalid, o_if_rvalid}, r.is_dm ? 32'd2 : 32'd1);
                    chk("rdata", r.is_dm ? o_dm_rdata : o_if_rdata, r.rdata);
                end
            end
        end
    end

    initial begin
        vec_t rows[6];
        int   waited;

        rows[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0,    0, 0, 32'h0050_0093, 1'b0, 4'hF};
        rows[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 2, 3, 32'h0,         1'b1, 4'b0011};
        rows[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,         4'hF,    1, 1, 32'h1234_5678, 1'b0, 4'hF};
        rows[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'h0,    0, 2, 32'hABCD_0001, 1'b0, 4'hF};
        rows[4] = '{1'b1, 1'b1, 32'h0000_3008, 32'hCAFE_F00D, 4'b1000, 0, 0, 32'h0,         1'b1, 4'b1000};
        rows[5] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,         4'h0,    3, 0, 32'h00A0_0113, 1'b0, 4'hF};

        i_reset = 1'b0;
        i_if_req = 1'b0; i_if_addr = '0; i_if_kill = 1'b0;
        i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_addr = '0; i_dm_wdata = '0; i_dm_be = '0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

        tick();
        tick();
        #1;
        chk("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
        chk("rst_rvalids", {30'b0, o_if_rvalid, o_dm_rvalid}, 32'd0);
        chk("rst_timeout", {31'b0, o_timeout}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        chk("rst_mem_we_be", {27'b0, o_mem_we, o_mem_be}, 32'd0);
        i_reset = 1'b1;
        tick();

        // Single transactions from the table, each with its own grant/response delays.
        for (int n = 0; n < 6; n++) begin
            if (rows[n].is_dm) begin
                i_dm_req   = 1'b1;
                i_dm_we    = rows[n].we;
                i_dm_addr  = rows[n].addr;
                i_dm_wdata = rows[n].wdata;
                i_dm_be    = rows[n].be;
            end else begin
                i_if_req   = 1'b1;
                i_if_addr  = rows[n].addr;
                i_dm_we    = 1'b1;
                i_dm_be    = 4'h1;
                i_dm_wdata = 32'hFFFF_FFFF;
            end
            iss_q.push_back('{rows[n].addr, rows[n].exp_we, rows[n].wdata, rows[n].exp_be, rows[n].is_dm});
            serve(rows[n].is_dm, 1'b1, rows[n].gdly, rows[n].rdly, rows[n].rdata, waited);
            chk("latency", waited, 32'd1);
            i_if_req = 1'b0;
            i_dm_req = 1'b0;
            $display("row %0d: %s addr 0x%08h done", n, rows[n].is_dm ? "DM" : "IF", rows[n].addr);
        end

        // Kill in flight: completion suppressed, the redirected fetch follows normally.
        tick();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0180;
        iss_q.push_back('{32'h0000_0180, 1'b0, 32'h0, 4'hF, 1'b0});
        tick();
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        i_if_kill = 1'b1;
        i_if_addr = 32'h0000_0200;
        #1 chk("kill_stall_f", {31'b0, o_stall_f}, 32'd0);
        tick();
        i_if_kill = 1'b0;
        #1 chk("kill_wait_stall_f", {31'b0, o_stall_f}, 32'd1);
        tick();
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hDEAD_0000;
        #1 chk("kill_no_rvalid", {31'b0, o_if_rvalid}, 32'd0);
        tick();
        i_mem_rvalid = 1'b0;
        iss_q.push_back('{32'h0000_0200, 1'b0, 32'h0, 4'hF, 1'b0});
        serve(1'b0, 1'b1, 0, 0, 32'h0000_0013, waited);
        chk("kill_next_latency", waited, 32'd1);
        i_if_req = 1'b0;
        $display("kill sequence done");

        // Reset asserted mid-WAIT on an IF transaction; a late response must be ignored.
        tick();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0600;
        iss_q.push_back('{32'h0000_0600, 1'b0, 32'h0, 4'hF, 1'b0});
        tick();
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        i_reset   = 1'b0;
        #1;
        chk("rstw_mem_req", {31'b0, o_mem_req}, 32'd0);
        chk("rstw_mem_addr", o_mem_addr, 32'd0);
        i_if_req = 1'b0;
        tick();
        i_reset      = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h5555_AAAA;
        #1 chk("rstw_late_rvalid", {30'b0, o_if_rvalid, o_dm_rvalid}, 32'd0);
        tick();
        i_mem_rvalid = 1'b0;
        #1 chk("rstw_idle", {31'b0, o_mem_req}, 32'd0);
        $display("reset mid-wait done");

        // Contention right after reset: IF first, then strict alternation.
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0400;
        i_dm_req  = 1'b1;
        i_dm_we   = 1'b0;
        i_dm_addr = 32'h0000_0500;
        i_dm_be   = 4'hF;
        iss_q.push_back('{32'h0000_0400, 1'b0, 32'h0, 4'hF, 1'b0});
        iss_q.push_back('{32'h0000_0500, 1'b0, 32'h0, 4'hF, 1'b0});
        #1 chk("cont_stall_m", {31'b0, o_stall_m}, 32'd1);
        serve(1'b0, 1'b1, 0, 1, 32'h1111_0001, waited);
        chk("cont_lat_if0", waited, 32'd1);
        i_if_addr = 32'h0000_0404;
        iss_q.push_back('{32'h0000_0404, 1'b0, 32'h0, 4'hF, 1'b0});
        serve(1'b1, 1'b1, 0, 0, 32'h2222_0002, waited);
        chk("cont_lat_dm0", waited, 32'd1);
        i_dm_addr = 32'h0000_0504;
        iss_q.push_back('{32'h0000_0504, 1'b0, 32'h0, 4'hF, 1'b0});
        serve(1'b0, 1'b1, 1, 0, 32'h3333_0003, waited);
        chk("cont_lat_if1", waited, 32'd1);
        i_if_req = 1'b0;
        serve(1'b1, 1'b1, 0, 1, 32'h4444_0004, waited);
        chk("cont_lat_dm1", waited, 32'd1);
        i_dm_req = 1'b0;
        $display("contention sequence done");

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: no grant ever; forced completion in the 4th busy cycle with zero data.
        tick();
        i_dm_req  = 1'b1;
        i_dm_we   = 1'b0;
        i_dm_addr = 32'h0000_0700;
        i_dm_be   = 4'hF;
        iss_q.push_back('{32'h0000_0700, 1'b0, 32'h0, 4'hF, 1'b1});
        for (int c = 1; c <= 3; c++) begin
            tick();
            #1;
            chk("to_no_rvalid", {31'b0, o_dm_rvalid}, 32'd0);
            chk("to_flag_low", {31'b0, o_timeout}, 32'd0);
        end
        tick();
        i_mem_rdata = 32'hFFFF_FFFF;
        rsp_q.push_back('{1'b1, 32'h0});
        #1 chk("to_force_rvalid", {31'b0, o_dm_rvalid}, 32'd1);
        tick();
        i_dm_req    = 1'b0;
        i_mem_rdata = '0;
        #1;
        chk("to_flag_set", {31'b0, o_timeout}, 32'd1);
        chk("to_idle", {31'b0, o_mem_req}, 32'd0);
        tick();
        tick();
        #1 chk("to_flag_sticky", {31'b0, o_timeout}, 32'd1);
        $display("timeout sequence done");
`else
        #1 chk("timeout_tied_low", {31'b0, o_timeout}, 32'd0);
`endif

        tick();
        tick();
        chk("sb_issue_left", iss_q.size(), 32'd0);
        chk("sb_resp_left", rsp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single memory port between instruction fetch (IF) and the data memory access of the MEM stage in the 5-stage RISC-V pipeline. It holds one outstanding transaction at a time and alternates grants when both ports contend. It generates per-stage stall requests that the top level ORs into StallF and the MEM-stage stall alongside the hazard unit's load-use stalls. It also handles a fetch cancelled by a taken branch (PCSrcE) while its memory access is in flight.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 wide
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_if_req  in  1  fetch request; held until o_if_rvalid or i_if_kill
- i_if_addr  in  ADDR_WIDTH  fetch address
- i_if_kill  in  1  discard the current or outstanding fetch (driven by PCSrcE)
- o_if_rdata  out  DATA_WIDTH  fetched instruction
- o_if_rvalid  out  1  fetch complete, 1-cycle pulse
- i_dm_req  in  1  data request; held until o_dm_rvalid
- i_dm_we  in  1  1 = store
- i_dm_addr  in  ADDR_WIDTH  data address
- i_dm_wdata  in  DATA_WIDTH  store data
- i_dm_be  in  DATA_WIDTH/8  byte enables
- o_dm_rdata  out  DATA_WIDTH  load data
- o_dm_rvalid  out  1  data access complete (load or store), 1-cycle pulse
- o_mem_req  out  1  memory request
- o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be  out  1/ADDR/DATA/DATA/8  registered request fields
- i_mem_gnt  in  1  memory accepted the request
- i_mem_rvalid  in  1  response or write acknowledge
- i_mem_rdata  in  DATA_WIDTH  response data
- o_stall_f  out  1  fetch stall request
- o_stall_m  out  1  MEM-stage stall request
- o_timeout  out  1  sticky watchdog flag

## Operation
- FSM states:
  - IDLE: arbitrate between the ports.
  - ISSUE: o_mem_req=1; request fields held stable until i_mem_gnt.
  - WAIT: await i_mem_rvalid.
- Arbitration in IDLE:
  - An IF candidate counts only when i_if_req=1 and i_if_kill=0.
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins; the last_owner flop is updated on every grant.
- Grant (IDLE→ISSUE): latch the owner, address, we, wdata and be. IF grants force we=0 and be all ones.
- ISSUE transitions:
  - i_mem_gnt=1 and i_mem_rvalid=0 → WAIT.
  - i_mem_gnt=1 and i_mem_rvalid=1 in the same cycle → complete immediately and go to IDLE.
- WAIT transition: i_mem_rvalid=1 → complete and go to IDLE.
- Completion: pulse o_<owner>_rvalid in the cycle i_mem_rvalid is seen. o_<owner>_rdata = i_mem_rdata, combinational pass-through.
- i_mem_rvalid is ignored in IDLE, and in ISSUE without i_mem_gnt.
- Kill:
  - i_if_kill=1 while the owner is IF in ISSUE or WAIT sets a killed flag.
  - The transaction still runs to completion; there is no withdrawal after o_mem_req.
  - o_if_rvalid is suppressed for it; the flag clears on completion.
- Stalls (combinational):
  - o_stall_f = i_if_req & ~o_if_rvalid & ~i_if_kill
  - o_stall_m = i_dm_req & ~o_dm_rvalid
- A requester that keeps req high in the cycle after its rvalid pulse is issuing a new request.
- Reset: asynchronous to IDLE.
  - last_owner = DATA, so the first contended grant goes to IF.
  - o_mem_req, o_if_rvalid, o_dm_rvalid, o_timeout = 0; request registers = 0; killed flag = 0.

## Timing
- Request present at edge k in IDLE → o_mem_req=1 in cycle k+1.
- Minimum latency, with i_mem_gnt and i_mem_rvalid both high on the first ISSUE cycle: rvalid pulse in cycle k+1, FSM back in IDLE at edge k+2.
- Back-to-back transactions have one IDLE bubble cycle between them.
- o_mem_* fields are registered and change only on the IDLE→ISSUE edge.
- A request arriving while busy waits. Its stall is asserted throughout the wait.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - An 8..16-bit counter runs in ISSUE/WAIT and is cleared on entering ISSUE.
  - When it reaches TIMEOUT_CYCLES, the transaction force-completes: owner rvalid pulses (unless killed), rdata=0, FSM goes to IDLE.
  - o_timeout goes to 1 and stays set until reset.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter; o_timeout tied 0.
  - The FSM waits indefinitely for gnt/rvalid.

## Test plan
- Lone fetch: i_if_req=1, addr 0x100; gnt and rvalid on the first ISSUE cycle with rdata 0x00500093 → o_mem_addr=0x100 and we=0; o_if_rvalid pulses with rdata 0x00500093; o_stall_f drops that cycle.
- Contention after reset: IF and DM request in the same cycle → IF is granted first, DM second. With both held continuously, grants alternate IF, DM, IF, DM.
- Store with wait states: DM we=1, addr 0x2000, wdata 0xDEADBEEF, be 4'b0011; gnt after 2 cycles, rvalid 3 cycles later → o_mem_* stable throughout; o_stall_m=1 until the single o_dm_rvalid pulse.
- Kill in flight: IF granted; i_if_kill pulsed in WAIT → o_if_rvalid stays 0 at completion; the next IF request (addr 0x200) is issued normally.
- Reset mid-WAIT: assert i_reset=0 asynchronously → o_mem_req=0 immediately; FSM in IDLE; a late i_mem_rvalid produces no rvalid pulse.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4: no gnt → force-completion after 4 cycles with owner rdata=0; o_timeout=1 and stays set.
